// File: rtl/pool_scheduler.sv
// pool_scheduler: job/result controller for NUM_POOLS hasher pool channels.
//   Starts and stops the pools. Supports two modes: stop on the first hit, or
//   scan the full range (with an optional cycle timeout). Each pool has a
//   one-deep pending latch. A round-robin arbiter moves one latched hit per
//   cycle into the result FIFO.
// Ports:
//   clk_in, reset_in          clock, synchronous active-high reset
//   start_in, abort_in        job control (abort wins over start)
//   scan_all_in               mode sampled with start_in (1 = full scan)
//   core_run_out[N]           per-pool run enable
//   hit_in/hit_nonce_in/
//   hit_flags_in/exhausted_in per-pool result and progress inputs
//   res_valid/data/pool_out   head of the result FIFO; res_pop_in pops it
//   busy/done/ready/overflow  status towards the IO block

// One-deep holding register for a single pool's {flags, nonce}.
module pool_latch (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        flush,
    input  logic        capture_en,
    input  logic        hit,
    input  logic [31:0] nonce,
    input  logic [7:0]  flags,
    input  logic        grant,
    output logic        full,
    output logic [39:0] data,
    output logic        drop
);
    // grant is only raised when full and capture only happens when empty,
    // so the two branches never compete.
    always_ff @(posedge clk_in) begin
        if (reset_in || flush) begin
            full <= 1'b0;
            data <= '0;
        end else if (grant) begin
            full <= 1'b0;
        end else if (capture_en && hit && !full) begin
            full <= 1'b1;
            data <= {flags, nonce};
        end
    end

    // If the latch is still occupied (even when it drains this cycle), the
    // new hit is lost.
    assign drop = capture_en && hit && full;
endmodule

module pool_scheduler #(
    parameter int NUM_POOLS       = 4,
    parameter int NUM_POOLS_LOG2  = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      start_in,
    input  logic                      abort_in,
    input  logic                      scan_all_in,
    output logic [NUM_POOLS-1:0]      core_run_out,
    input  logic [NUM_POOLS-1:0]      hit_in,
    input  logic [32*NUM_POOLS-1:0]   hit_nonce_in,
    input  logic [8*NUM_POOLS-1:0]    hit_flags_in,
    input  logic [NUM_POOLS-1:0]      exhausted_in,
    output logic                      res_valid_out,
    output logic [39:0]               res_data_out,
    output logic [NUM_POOLS_LOG2-1:0] res_pool_out,
    input  logic                      res_pop_in,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      ready_out,
    output logic                      overflow_out
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_DONE} state_t;
    typedef struct packed {
        logic [NUM_POOLS_LOG2-1:0] pool;
        logic [39:0]               data;
    } res_t;

    localparam logic [31:0]                TMO_LIMIT = 32'(TIMEOUT_CYCLES);
    localparam logic [FIFO_DEPTH_LOG2:0]   FIFO_FULL = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH);
    localparam logic [NUM_POOLS_LOG2-1:0]  LAST_POOL = NUM_POOLS_LOG2'(NUM_POOLS-1);

    state_t                           state, state_nxt;
    logic                             mode;
    logic [31:0]                      tmo_cnt;
    logic [NUM_POOLS-1:0]             exh_mask, pend_full, drop, grant_vec;
    logic [NUM_POOLS-1:0][39:0]       pend_data;
    logic [NUM_POOLS_LOG2-1:0]        rr_ptr, rr_nxt, grant_idx;
    logic                             grant_any, push, pop, start_ok, run_stop;
    res_t                             fifo_mem [FIFO_DEPTH];
    res_t                             head;
    logic [FIFO_DEPTH_LOG2-1:0]       wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]         fifo_cnt;

    // ---------------- per-pool pending latches ----------------
    generate
        for (genvar i = 0; i < NUM_POOLS; i++) begin : g_pool
            assign grant_vec[i] = push && (grant_idx == NUM_POOLS_LOG2'(i));
            pool_latch u_latch (
                .clk_in     (clk_in),
                .reset_in   (reset_in),
                .flush      (abort_in),
                .capture_en (state == S_RUN),
                .hit        (hit_in[i]),
                .nonce      (hit_nonce_in[32*i +: 32]),
                .flags      (hit_flags_in[8*i +: 8]),
                .grant      (grant_vec[i]),
                .full       (pend_full[i]),
                .data       (pend_data[i]),
                .drop       (drop[i])
            );
        end
    endgenerate

    // ---------------- round-robin arbiter ----------------
    always_comb begin
        int idx;
        logic [NUM_POOLS_LOG2-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_POOLS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_POOLS) idx = idx - NUM_POOLS;
            cand = NUM_POOLS_LOG2'(idx);
            if (!grant_any && pend_full[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign rr_nxt = (grant_idx == LAST_POOL) ? '0 : grant_idx + 1'b1;
    assign pop    = res_pop_in && (fifo_cnt != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push   = grant_any && !abort_in && ((fifo_cnt != FIFO_FULL) || pop);

    always_ff @(posedge clk_in) begin
        if (reset_in)  rr_ptr <= '0;
        else if (push) rr_ptr <= rr_nxt;
    end

    // ---------------- result FIFO ----------------
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr] <= '{pool: grant_idx, data: pend_data[grant_idx]};
    end

    always_ff @(posedge clk_in) begin
        if (reset_in || abort_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign head          = fifo_mem[rd_ptr];
    assign res_valid_out = (fifo_cnt != '0);
    // Gate the head so the outputs read zero while the storage is unwritten.
    assign res_data_out  = res_valid_out ? head.data : '0;
    assign res_pool_out  = res_valid_out ? head.pool : '0;

    // ---------------- job bookkeeping ----------------
    assign start_ok = start_in && !abort_in && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mode     <= 1'b0;
            tmo_cnt  <= '0;
            exh_mask <= '0;
        end else if (start_ok) begin
            mode     <= scan_all_in;
            tmo_cnt  <= '0;
            exh_mask <= '0;
        end else if (state == S_RUN) begin
            tmo_cnt  <= tmo_cnt + 32'd1;
            exh_mask <= exh_mask | exhausted_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in)                    overflow_out <= 1'b0;
        else if (start_ok)               overflow_out <= 1'b0;
        else if (|drop && !abort_in)     overflow_out <= 1'b1;
    end

    // tmo_cnt + 1 is the index of the current RUN cycle (1 on the first one).
    always_comb begin
        logic exh_all, tmo_hit;
        exh_all  = &(exh_mask | exhausted_in);
        tmo_hit  = (TMO_LIMIT != '0) && ((tmo_cnt + 32'd1) == TMO_LIMIT);
        run_stop = mode ? (exh_all || tmo_hit) : (|hit_in);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in) begin
        if (reset_in) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort_in) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start_in)    state_nxt = S_RUN;
                S_RUN:          if (run_stop)    state_nxt = S_STOP;
                S_STOP:         if (~|pend_full) state_nxt = S_DONE;
                default:                         state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_out     = 1'b0;
        done_out     = 1'b0;
        core_run_out = '0;
        case (state)
            S_RUN:  begin busy_out = 1'b1; core_run_out = '1; end
            S_STOP: busy_out = 1'b1;
            S_DONE: done_out = 1'b1;
            default: ;
        endcase
    end

    assign ready_out = res_valid_out | done_out;
endmodule

// File: tb/tb_pool_scheduler.sv
// Directed bench for pool_scheduler. Three instances share one stimulus:
//   dut_a: defaults (FIFO 4, no timeout)  -- table-driven vectors
//   dut_b: FIFO_DEPTH=2                   -- back-pressure / overflow sequence
//   dut_c: TIMEOUT_CYCLES=10              -- timeout sequence
module tb_pool_scheduler;
    logic         clk = 1'b0;
    logic         reset, start, abort, scan, pop;
    logic [3:0]   hit, exh;
    logic [127:0] nonce_v;
    logic [31:0]  flags_v;

    logic [3:0]  a_run, b_run, c_run;
    logic        a_rv, b_rv, c_rv, a_busy, b_busy, c_busy, a_done, b_done, c_done;
    logic        a_rdy, b_rdy, c_rdy, a_ovf, b_ovf, c_ovf;
    logic [39:0] a_data, b_data, c_data;
    logic [1:0]  a_pool, b_pool, c_pool;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [39:0] D0 = 40'h10_AAAA_0000;
    localparam logic [39:0] D1 = 40'h21_BBBB_1111;
    localparam logic [39:0] D2 = 40'h01_1234_5678;
    localparam logic [39:0] D3 = 40'h43_DDDD_3333;

    always #5 clk = ~clk;

    pool_scheduler #(.NUM_POOLS(4), .NUM_POOLS_LOG2(2), .FIFO_DEPTH(4),
                     .FIFO_DEPTH_LOG2(2), .TIMEOUT_CYCLES(0)) dut_a (
        .clk_in(clk), .reset_in(reset), .start_in(start), .abort_in(abort),
        .scan_all_in(scan), .core_run_out(a_run), .hit_in(hit),
        .hit_nonce_in(nonce_v), .hit_flags_in(flags_v), .exhausted_in(exh),
        .res_valid_out(a_rv), .res_data_out(a_data), .res_pool_out(a_pool),
        .res_pop_in(pop), .busy_out(a_busy), .done_out(a_done),
        .ready_out(a_rdy), .overflow_out(a_ovf));

    pool_scheduler #(.NUM_POOLS(4), .NUM_POOLS_LOG2(2), .FIFO_DEPTH(2),
                     .FIFO_DEPTH_LOG2(1), .TIMEOUT_CYCLES(0)) dut_b (
        .clk_in(clk), .reset_in(reset), .start_in(start), .abort_in(abort),
        .scan_all_in(scan), .core_run_out(b_run), .hit_in(hit),
        .hit_nonce_in(nonce_v), .hit_flags_in(flags_v), .exhausted_in(exh),
        .res_valid_out(b_rv), .res_data_out(b_data), .res_pool_out(b_pool),
        .res_pop_in(pop), .busy_out(b_busy), .done_out(b_done),
        .ready_out(b_rdy), .overflow_out(b_ovf));

    pool_scheduler #(.NUM_POOLS(4), .NUM_POOLS_LOG2(2), .FIFO_DEPTH(4),
                     .FIFO_DEPTH_LOG2(2), .TIMEOUT_CYCLES(10)) dut_c (
        .clk_in(clk), .reset_in(reset), .start_in(start), .abort_in(abort),
        .scan_all_in(scan), .core_run_out(c_run), .hit_in(hit),
        .hit_nonce_in(nonce_v), .hit_flags_in(flags_v), .exhausted_in(exh),
        .res_valid_out(c_rv), .res_data_out(c_data), .res_pool_out(c_pool),
        .res_pop_in(pop), .busy_out(c_busy), .done_out(c_done),
        .ready_out(c_rdy), .overflow_out(c_ovf));

    typedef struct {
        logic        st, ab, sc;
        logic [3:0]  hit, exh;
        logic        pop;
        logic [3:0]  e_run;
        logic        e_busy, e_done, e_rv;
        logic [1:0]  e_pool;
        logic [39:0] e_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic ab, logic sc, logic [3:0] h,
                                logic [3:0] x, logic p, logic [3:0] r,
                                logic b, logic d, logic v, logic [1:0] pl,
                                logic [39:0] dt);
        vec_t t;
        t.st = st; t.ab = ab; t.sc = sc; t.hit = h; t.exh = x; t.pop = p;
        t.e_run = r; t.e_busy = b; t.e_done = d; t.e_rv = v;
        t.e_pool = pl; t.e_data = dt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; pop = 1'b0; hit = '0; exh = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        scan  = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        nonce_v = {32'hDDDD_3333, 32'h1234_5678, 32'hBBBB_1111, 32'hAAAA_0000};
        flags_v = {8'h43, 8'h01, 8'h21, 8'h10};
        do_reset();

        // reset state
        chk("rst.run",  a_run,  0);
        chk("rst.busy", a_busy, 0);
        chk("rst.done", a_done, 0);
        chk("rst.rv",   a_rv,   0);
        chk("rst.rdy",  a_rdy,  0);
        chk("rst.ovf",  a_ovf,  0);
        chk("rst.data", a_data, 0);
        chk("rst.pool", a_pool, 0);

        //             st ab sc hit     exh     pop run   bsy dn rv pool data
        // single hit, stop-on-first-hit
        tbl.push_back(mk(1,0,0,4'b0000,4'b0000,0, 4'hF, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'hF, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0100,4'b0000,0, 4'h0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 1,0,1,2,D2));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 0,1,1,2,D2));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,1, 4'h0, 0,1,0,0,0));
        // pool 0 job to move the RR pointer to 1
        tbl.push_back(mk(1,0,0,4'b0000,4'b0000,0, 4'hF, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0001,4'b0000,0, 4'h0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 1,0,1,0,D0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,1, 4'h0, 0,1,0,0,0));
        // coincident hits 0,1,3 with RR pointer 1 -> order 1,3,0
        tbl.push_back(mk(1,0,0,4'b0000,4'b0000,0, 4'hF, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b1011,4'b0000,0, 4'h0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 1,0,1,1,D1));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 1,0,1,1,D1));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 1,0,1,1,D1));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 0,1,1,1,D1));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,1, 4'h0, 0,1,1,3,D3));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,1, 4'h0, 0,1,1,0,D0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,1, 4'h0, 0,1,0,0,0));
        // full scan, exhausted bits one per cycle
        tbl.push_back(mk(1,0,1,4'b0000,4'b0000,0, 4'hF, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0010,4'b0001,0, 4'hF, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b1000,4'b0010,0, 4'hF, 1,0,1,1,D1));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0100,0, 4'hF, 1,0,1,1,D1));
        tbl.push_back(mk(0,0,0,4'b0001,4'b1000,0, 4'h0, 1,0,1,1,D1));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 1,0,1,1,D1));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 0,1,1,1,D1));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,1, 4'h0, 0,1,1,3,D3));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,1, 4'h0, 0,1,1,0,D0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,1, 4'h0, 0,1,0,0,0));
        // abort with one FIFO entry and one pending latch; abort beats start
        tbl.push_back(mk(1,0,0,4'b0000,4'b0000,0, 4'hF, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0101,4'b0000,0, 4'h0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 1,0,1,2,D2));
        tbl.push_back(mk(1,1,0,4'b0000,4'b0000,0, 4'h0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 0,0,0,0,0));
        tbl.push_back(mk(1,0,0,4'b0000,4'b0000,0, 4'hF, 1,0,0,0,0));
        tbl.push_back(mk(0,1,0,4'b0000,4'b0000,0, 4'h0, 0,0,0,0,0));
        // hits while IDLE are ignored
        tbl.push_back(mk(0,0,0,4'b1111,4'b0000,0, 4'h0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,0, 4'h0, 0,0,0,0,0));

        foreach (tbl[i]) begin
            start = tbl[i].st; abort = tbl[i].ab; scan = tbl[i].sc;
            hit = tbl[i].hit; exh = tbl[i].exh; pop = tbl[i].pop;
            tick();
            chk($sformatf("v%0d.run",  i), a_run,  tbl[i].e_run);
            chk($sformatf("v%0d.busy", i), a_busy, tbl[i].e_busy);
            chk($sformatf("v%0d.done", i), a_done, tbl[i].e_done);
            chk($sformatf("v%0d.rv",   i), a_rv,   tbl[i].e_rv);
            chk($sformatf("v%0d.pool", i), a_pool, tbl[i].e_pool);
            chk($sformatf("v%0d.data", i), a_data, tbl[i].e_data);
            chk($sformatf("v%0d.rdy",  i), a_rdy,  tbl[i].e_rv | tbl[i].e_done);
            chk($sformatf("v%0d.ovf",  i), a_ovf,  0);
        end
        idle_inputs();

        // FIFO_DEPTH=2 back-pressure, drop and RR drain on dut_b
        do_reset();
        start = 1; scan = 1; tick(); start = 0;
        hit = 4'b0001; tick();
        hit = 4'b0010; tick();
        hit = 4'b0100; tick();
        hit = 4'b1000; tick();
        hit = 4'b0000;
        chk("bp.rv",   b_rv,   1);
        chk("bp.head", b_data, D0);
        chk("bp.pool", b_pool, 0);
        chk("bp.ovf0", b_ovf,  0);
        nonce_v[31:0] = 32'hCAFE_F00D;
        hit = 4'b0001; tick();
        chk("bp.ovf1", b_ovf, 0);
        nonce_v[31:0] = 32'hDEAD_BEEF;
        hit = 4'b0001; tick();
        hit = 4'b0000;
        chk("bp.ovf2", b_ovf, 1);
        chk("bp.run",  b_run, 4'hF);
        pop = 1;
        tick(); chk("bp.pop1.pool", b_pool, 1); chk("bp.pop1.data", b_data, D1);
        tick(); chk("bp.pop2.pool", b_pool, 2); chk("bp.pop2.data", b_data, D2);
        tick(); chk("bp.pop3.pool", b_pool, 3); chk("bp.pop3.data", b_data, D3);
        tick(); chk("bp.pop4.pool", b_pool, 0); chk("bp.pop4.data", b_data, 40'h10_CAFE_F00D);
        tick(); chk("bp.pop5.rv",   b_rv,   0);
        pop = 0;
        chk("bp.ovf3", b_ovf, 1);
        abort = 1; tick(); abort = 0;
        chk("bp.abort.ovf",  b_ovf,  1);
        chk("bp.abort.busy", b_busy, 0);
        start = 1; scan = 0; tick(); start = 0;
        chk("bp.restart.ovf", b_ovf, 0);
        nonce_v[31:0] = 32'hAAAA_0000;

        // timeout on dut_c: exactly 10 RUN cycles; dut_a has it disabled
        do_reset();
        start = 1; scan = 1; tick(); start = 0;
        chk("tmo.run.1", c_run, 4'hF);
        for (int k = 2; k <= 10; k++) begin
            tick();
            chk($sformatf("tmo.run.%0d", k), c_run, 4'hF);
        end
        tick();
        chk("tmo.stop.run",  c_run,  0);
        chk("tmo.stop.busy", c_busy, 1);
        chk("tmo.off.run",   a_run,  4'hF);
        tick();
        chk("tmo.done", c_done, 1);

        // reset in the middle of a job
        reset = 1; tick(); reset = 0;
        chk("mid.busy", a_busy, 0);
        chk("mid.run",  a_run,  0);
        chk("mid.done", c_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
